// File: rtl/disk_dma_responder.sv
// disk_dma_responder
// System-side responder for HPS sector DMA. The emulated disk controller posts
// a one-sector operation (req_read/req_write). The block raises disk_op_read or
// disk_op_write towards the HPS and serves the HPS's Avalon-MM word accesses to
// a 128x32 sector buffer plus two read-only op registers. It completes when the
// HPS reports disk_result_ok or disk_result_error, or when the timeout expires.
//
// Ports
//   clk_sys, rst_n             system clock, asynchronous active-low reset
//   avs_*                      Avalon-MM slave driven by the HPS DMA master
//                              (0-127 buffer, 128 LBA, 129 op status, others reserved)
//   req_*                      operation request from the disk controller
//   busy, done, error          operation status back to the controller
//   host_addr/we/wdata/rdata   controller-local buffer port (1-cycle read latency)
//   disk_op_*                  level request to the HPS
//   disk_result_ok/error       level completion from the HPS
module disk_dma_responder #(
  parameter int unsigned BUF_AW      = 7,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [7:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic              avs_waitrequest,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic              req_device,
  input  logic [31:0]       req_lba,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic [BUF_AW-1:0] host_addr,
  input  logic              host_we,
  input  logic [31:0]       host_wdata,
  output logic [31:0]       host_rdata,
  output logic              disk_op_read,
  output logic              disk_op_write,
  output logic              disk_op_device,
  input  logic              disk_result_ok,
  input  logic              disk_result_error
);

  localparam int unsigned DEPTH = 1 << BUF_AW;
  localparam int unsigned CW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, CLR} state_t;

  state_t            state, state_next;
  logic              ready;
  logic [31:0]       lba;
  logic              dir;        // 1 = write buffer to image
  logic              device;
  logic [CW-1:0]     tcnt;
  logic              timeout;
  logic              accept;
  logic              buf_hit;
  logic              av_wr, av_rd;
  logic [BUF_AW-1:0] av_idx;
  logic [31:0]       rd_word;
  logic [31:0]       rd_data1;
  logic              rd_valid1;
  logic [31:0]       mem [DEPTH];

  assign buf_hit = ~avs_address[7];
  assign av_idx  = avs_address[BUF_AW-1:0];

  // ready is low only while in reset, which keeps waitrequest high there.
  // The host port owns the buffer write port, so a colliding Avalon buffer
  // write is stalled for that cycle.
  assign avs_waitrequest = ~ready | (host_we & avs_write & buf_hit);
  assign av_wr = avs_write & ~avs_waitrequest;
  assign av_rd = avs_read & ~avs_waitrequest;

  assign accept  = (state == IDLE) & (req_read | req_write);
  assign timeout = TO_EN & (state == REQ) & (tcnt == TO_LAST);
  assign busy    = (state != IDLE);
  assign disk_op_device = device;

  always_comb begin
    state_next    = state;
    done          = 1'b0;
    disk_op_read  = 1'b0;
    disk_op_write = 1'b0;
    case (state)
      IDLE: if (req_read | req_write) state_next = REQ;
      REQ: begin
        disk_op_read  = ~dir;
        disk_op_write = dir;
        if (disk_result_ok | disk_result_error | timeout) state_next = CLR;
      end
      CLR: begin
        if (!disk_result_ok && !disk_result_error) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ready  <= 1'b0;
      lba    <= '0;
      dir    <= 1'b0;
      device <= 1'b0;
      error  <= 1'b0;
      tcnt   <= '0;
    end else begin
      state <= state_next;
      ready <= 1'b1;
      tcnt  <= (state == REQ) ? tcnt + 1'b1 : '0;
      if (accept) begin
        lba    <= req_lba;
        dir    <= ~req_read;
        device <= req_device;
        error  <= 1'b0;
      end
      if (state == REQ) begin
        if (disk_result_error | timeout) error <= 1'b1;
        else if (disk_result_ok)         error <= 1'b0;
      end
    end
  end

  // Buffer RAM: not reset. Host write and Avalon write are mutually exclusive
  // because the Avalon write is stalled on collision.
  always_ff @(posedge clk_sys) begin
    if (host_we) begin
      mem[host_addr] <= host_wdata;
    end else if (av_wr && buf_hit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (avs_byteenable[b]) mem[av_idx][8*b +: 8] <= avs_writedata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (buf_hit)                         rd_word = mem[av_idx];
    else if (avs_address[6:0] == 7'd0)   rd_word = lba;
    else if (avs_address[6:0] == 7'd1)   rd_word = {29'b0, busy, dir, device};
  end

  // Two-stage read pipeline gives a fixed 2-cycle accept-to-valid latency.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid1         <= 1'b0;
      rd_data1          <= '0;
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= '0;
      host_rdata        <= '0;
    end else begin
      rd_valid1         <= av_rd;
      if (av_rd) rd_data1 <= rd_word;
      avs_readdatavalid <= rd_valid1;
      if (rd_valid1) avs_readdata <= rd_data1;
      host_rdata        <= mem[host_addr];
    end
  end

endmodule

// File: tb/tb_disk_dma_responder.sv
module tb_disk_dma_responder;

  localparam int unsigned TO = 16;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        req_read, req_write, req_device;
  logic [31:0] req_lba;
  logic        busy, done, error;
  logic [6:0]  host_addr;
  logic        host_we;
  logic [31:0] host_wdata, host_rdata;
  logic        disk_op_read, disk_op_write, disk_op_device;
  logic        disk_result_ok, disk_result_error;

  always #5 clk_sys = ~clk_sys;

  disk_dma_responder #(.BUF_AW(7), .TIMEOUT_CYC(TO)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .req_read(req_read), .req_write(req_write), .req_device(req_device), .req_lba(req_lba),
    .busy(busy), .done(done), .error(error),
    .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .disk_op_read(disk_op_read), .disk_op_write(disk_op_write), .disk_op_device(disk_op_device),
    .disk_result_ok(disk_result_ok), .disk_result_error(disk_result_error)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state
  logic [31:0] m_mem [128];
  bit          m_known [128];
  logic [31:0] m_lba;
  logic        m_dir, m_dev, m_busy, m_opr, m_opw, m_err, m_done;

  typedef struct { int due; logic [31:0] data; bit chk; } rd_t;
  rd_t rq[$];

  typedef struct { logic [31:0] init; logic [31:0] wdata; logic [3:0] be; logic [31:0] exp; } be_vec_t;
  be_vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic idle_in();
    avs_read = 0; avs_write = 0; avs_address = '0; avs_writedata = '0; avs_byteenable = '0;
    req_read = 0; req_write = 0; req_device = 0; req_lba = '0;
    host_we = 0; host_wdata = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (!a[7])        return m_mem[a[6:0]];
    if (a == 8'd128)  return m_lba;
    if (a == 8'd129)  return {29'b0, m_busy, m_dir, m_dev};
    return 32'h0;
  endfunction

  // One clock with inputs already driven: check combinational/status outputs
  // before the edge, advance the model, then check registered outputs after.
  task automatic run_cycle();
    rd_t r;
    logic stall, acc, exp_v, hr_chk;
    logic [31:0] hr_exp, mask;
    #1;
    stall = host_we && avs_write && !avs_address[7];
    check("waitrequest", {31'b0, avs_waitrequest}, {31'b0, stall});
    check("busy", {31'b0, busy}, {31'b0, m_busy});
    check("disk_op_read", {31'b0, disk_op_read}, {31'b0, m_opr});
    check("disk_op_write", {31'b0, disk_op_write}, {31'b0, m_opw});
    check("disk_op_device", {31'b0, disk_op_device}, {31'b0, m_dev});
    check("error", {31'b0, error}, {31'b0, m_err});
    check("done", {31'b0, done}, {31'b0, m_done});
    if (avs_read) begin
      r.due  = cyc + 2;
      r.data = m_read(avs_address);
      r.chk  = avs_address[7] || m_known[avs_address[6:0]];
      rq.push_back(r);
    end
    hr_chk = m_known[host_addr];
    hr_exp = m_mem[host_addr];
    if (host_we) begin
      m_mem[host_addr]   = host_wdata;
      m_known[host_addr] = 1'b1;
    end else if (avs_write && !avs_address[7]) begin
      mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}}, {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
      m_mem[avs_address[6:0]] = (m_mem[avs_address[6:0]] & ~mask) | (avs_writedata & mask);
      if (avs_byteenable == 4'hF) m_known[avs_address[6:0]] = 1'b1;
    end
    acc = !m_busy && (req_read || req_write);
    if (acc) begin
      m_lba = req_lba; m_dir = !req_read; m_dev = req_device;
    end
    @(posedge clk_sys);
    cyc++;
    #1;
    if (acc) begin
      m_busy = 1; m_opr = !m_dir; m_opw = m_dir; m_err = 0;
    end
    m_done = 0;
    exp_v = (rq.size() > 0) && (rq[0].due == cyc);
    check("readdatavalid", {31'b0, avs_readdatavalid}, {31'b0, exp_v});
    if (exp_v) begin
      r = rq.pop_front();
      if (r.chk) check("readdata", avs_readdata, r.data);
    end
    if (hr_chk) check("host_rdata", host_rdata, hr_exp);
  endtask

  task automatic av_read(input logic [7:0] a);
    avs_read = 1; avs_address = a; run_cycle();
    avs_read = 0; run_cycle(); run_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    tbl[0] = '{32'h11223344, 32'hAABBCCDD, 4'b0010, 32'h1122CC44};
    tbl[1] = '{32'h11223344, 32'hAABBCCDD, 4'b0000, 32'h11223344};
    tbl[2] = '{32'h11223344, 32'hAABBCCDD, 4'b1111, 32'hAABBCCDD};
    tbl[3] = '{32'h11223344, 32'hAABBCCDD, 4'b0001, 32'h112233DD};
    tbl[4] = '{32'h11223344, 32'hAABBCCDD, 4'b1000, 32'hAA223344};
    tbl[5] = '{32'h11223344, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD};
    tbl[6] = '{32'h00000000, 32'hFFFFFFFF, 4'b0110, 32'h00FFFF00};

    for (int i = 0; i < 128; i++) begin m_mem[i] = '0; m_known[i] = 0; end
    m_lba = '0; m_dir = 0; m_dev = 0; m_busy = 0; m_opr = 0; m_opw = 0; m_err = 0; m_done = 0;
    idle_in(); host_addr = '0; disk_result_ok = 0; disk_result_error = 0;

    // Reset state
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst waitrequest", {31'b0, avs_waitrequest}, 32'd1);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst disk_op_read", {31'b0, disk_op_read}, 32'd0);
    check("rst disk_op_write", {31'b0, disk_op_write}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst error", {31'b0, error}, 32'd0);
    check("rst readdatavalid", {31'b0, avs_readdatavalid}, 32'd0);
    rst_n = 1; #1;
    check("release waitrequest", {31'b0, avs_waitrequest}, 32'd1);
    @(posedge clk_sys); cyc++; #1;
    av_read(8'd129);

    // Read op: buffer filled by HPS, completes with ok
    for (int i = 16; i < 128; i++) begin
      avs_write = 1; avs_address = 8'(i); avs_writedata = 32'(i) * 32'h01010101; avs_byteenable = 4'hF;
      run_cycle();
    end
    idle_in();
    req_read = 1; req_lba = 32'h1234; req_device = 1; run_cycle(); idle_in();
    for (int i = 0; i < 12; i++) begin
      avs_write = 1; avs_address = 8'(i); avs_writedata = 32'(i) * 32'h01010101; avs_byteenable = 4'hF;
      run_cycle();
    end
    idle_in();
    disk_result_ok = 1; run_cycle(); m_opr = 0;
    disk_result_ok = 0; m_done = 1; run_cycle(); m_busy = 0;
    host_addr = 7'd5; run_cycle();
    check("host_rdata word5", host_rdata, 32'h05050505);
    av_read(8'd128);
    av_read(8'd129);

    // Write op with back-to-back burst reads spanning REQ and CLR
    host_addr = 7'd3; host_we = 1; host_wdata = 32'hDEADBEEF;
    req_write = 1; req_lba = 32'hABCD0042; req_device = 0; run_cycle(); idle_in();
    for (int i = 0; i < 130; i++) begin
      avs_read = 1; avs_address = 8'(i);
      if (i == 10) disk_result_ok = 1;
      run_cycle();
      if (i == 10) m_opw = 0;
    end
    avs_read = 0; run_cycle(); run_cycle();
    disk_result_ok = 0; m_done = 1; run_cycle(); m_busy = 0;
    run_cycle();

    // ok and error together: error wins; done only after both drop
    req_read = 1; req_lba = 32'h7; run_cycle(); idle_in();
    run_cycle();
    disk_result_ok = 1; disk_result_error = 1; run_cycle(); m_opr = 0; m_err = 1;
    disk_result_ok = 0; run_cycle();
    disk_result_error = 0; m_done = 1; run_cycle(); m_busy = 0;
    run_cycle();
    req_write = 1; req_lba = 32'h8; run_cycle(); idle_in();
    check("error cleared by req", {31'b0, error}, 32'd0);
    disk_result_ok = 1; run_cycle(); m_opw = 0;
    disk_result_ok = 0; m_done = 1; run_cycle(); m_busy = 0;

    // Timeout with no HPS response; a request while busy is ignored
    req_read = 1; req_lba = 32'h55; req_device = 1; run_cycle(); idle_in();
    for (int k = 0; k < 16; k++) begin
      if (k == 5) begin req_read = 1; req_lba = 32'h99; req_device = 0; end
      run_cycle(); idle_in();
    end
    check("timeout error", {31'b0, error}, 32'd1);
    m_opr = 0; m_err = 1; m_done = 1; run_cycle(); m_busy = 0;
    av_read(8'd128);
    av_read(8'd129);

    // Byte-enable table
    for (int i = 0; i < 7; i++) begin
      a = 8'(20 + i);
      host_we = 1; host_addr = a[6:0]; host_wdata = tbl[i].init; run_cycle(); host_we = 0;
      avs_write = 1; avs_address = a; avs_writedata = tbl[i].wdata; avs_byteenable = tbl[i].be;
      run_cycle(); avs_write = 0;
      avs_read = 1; avs_address = a; run_cycle(); avs_read = 0; run_cycle();
      check("byteenable merge", avs_readdata, tbl[i].exp);
    end
    idle_in();

    // Host/Avalon write collision, then held write completes
    host_we = 1; host_addr = 7'd40; host_wdata = 32'h0BADF00D;
    avs_write = 1; avs_address = 8'd41; avs_writedata = 32'h12345678; avs_byteenable = 4'hF;
    #1;
    check("collision waitrequest", {31'b0, avs_waitrequest}, 32'd1);
    run_cycle();
    host_we = 0; run_cycle();
    avs_write = 0;
    av_read(8'd41);
    av_read(8'd40);
    // Same-cycle host read and Avalon write of one word returns old data
    host_addr = 7'd41; avs_write = 1; avs_address = 8'd41; avs_writedata = 32'hCAFEF00D;
    run_cycle();
    check("host old data", host_rdata, 32'h12345678);
    avs_write = 0; run_cycle();
    check("host new data", host_rdata, 32'hCAFEF00D);
    // Register write alongside host write: no stall, dropped
    host_we = 1; host_addr = 7'd50; host_wdata = 32'h50505050;
    avs_write = 1; avs_address = 8'd128; avs_writedata = 32'hFFFFFFFF; run_cycle();
    idle_in();
    av_read(8'd128);
    av_read(8'd200);

    // Randomized buffer/register traffic while idle
    for (int n = 0; n < 400; n++) begin
      idle_in();
      host_addr = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) begin host_we = 1; host_wdata = $urandom; end
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
      case ($urandom_range(0, 2))
        0: begin avs_read = 1; avs_address = a; end
        1: begin avs_write = 1; avs_address = a; avs_writedata = $urandom; avs_byteenable = 4'($urandom); end
        default: ;
      endcase
      run_cycle();
    end
    idle_in(); run_cycle(); run_cycle();

    // Asynchronous reset in the middle of REQ with a read in flight
    req_read = 1; req_lba = 32'h77; run_cycle(); idle_in();
    run_cycle();
    avs_read = 1; avs_address = 8'd3; run_cycle(); avs_read = 0;
    rst_n = 0; #1;
    check("midrst disk_op_read", {31'b0, disk_op_read}, 32'd0);
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst done", {31'b0, done}, 32'd0);
    check("midrst waitrequest", {31'b0, avs_waitrequest}, 32'd1);
    rq.delete();
    m_busy = 0; m_opr = 0; m_opw = 0; m_err = 0; m_lba = '0; m_dir = 0; m_dev = 0;
    repeat (2) begin @(posedge clk_sys); cyc++; end
    #1;
    check("midrst readdatavalid", {31'b0, avs_readdatavalid}, 32'd0);
    rst_n = 1;
    @(posedge clk_sys); cyc++; #1;
    repeat (4) run_cycle();
    av_read(8'd129);
    av_read(8'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
